// File: rtl/debouncer_multi.sv
// Multi-channel input debouncer.
// Each channel synchronises its raw input and filters it either by locking
// out further changes for CLK_WAIT cycles after following an edge (MODE=0),
// or by accepting a change only after it has held for CLK_WAIT+1 samples
// (MODE=1). Level, rise/fall strobes and busy flags are provided per channel.
module debouncer_multi #(
    parameter int CHANNELS    = 4,
    parameter int CLK_WAIT    = 2500000,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_raw,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_any_change,
    output logic [CHANNELS-1:0] o_busy
);

    localparam int              CNT_W    = $clog2(CLK_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        QUAL
    } state_t;

    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   rise_c, fall_c, busy_c;

        assign s = sync_q[SYNC_STAGES-1];

        // Input synchroniser: shift the raw level towards the last stage.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            end else begin
                sync_q <= SYNC_STAGES'({sync_q, i_raw[k]});
            end
        end

        // State register: FSM state, hold counter and debounced level.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= INIT_LEVEL;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        // Next-state logic for both filtering modes.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            case (state_q)
                IDLE: begin
                    if (s != level_q) begin
                        cnt_d = '0;
                        if (MODE == 0) begin
                            level_d = s;
                            state_d = LOCK;
                        end else begin
                            state_d = QUAL;
                        end
                    end
                end
                LOCK: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                QUAL: begin
                    if (s == level_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        level_d = s;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Output decode: edge of the level about to be registered, busy flag.
        always_comb begin
            rise_c = level_d & ~level_q;
            fall_c = ~level_d & level_q;
            busy_c = (state_q != IDLE);
        end

        assign rise_d[k]  = rise_c;
        assign fall_d[k]  = fall_c;
        assign o_level[k] = level_q;
        assign o_busy[k]  = busy_c;
    end

    // Strobe registers: aligned with the first cycle the new level is visible.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rise       <= '0;
            o_fall       <= '0;
            o_any_change <= 1'b0;
        end else begin
            o_rise       <= rise_d;
            o_fall       <= fall_d;
            o_any_change <= |(rise_d | fall_d);
        end
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Debounces N independent asynchronous inputs (buttons, switches, probe trigger lines) in one clock domain. Each channel has a built-in input synchroniser.
- Two selectable filtering modes:
  - LOCKOUT: follow immediately, then ignore the input for a hold time.
  - STABLE: accept a change only after the input has been steady for the hold time.
- Outputs per channel: the debounced level and one-cycle rise/fall strobes. These feed the analyzer's trigger/control logic.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- CLK_WAIT, 2500000, hold/qualification time in i_clk cycles (>=2).
- MODE, 0, 0 = LOCKOUT, 1 = STABLE (applies to all channels).
- SYNC_STAGES, 2, synchroniser flops per channel (1..4).
- INIT_LEVEL, 0, reset value (0/1) of every synchroniser flop and every o_level bit.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_raw  in  CHANNELS  asynchronous raw inputs
- o_level  out  CHANNELS  debounced levels
- o_rise  out  CHANNELS  one-cycle pulse when o_level goes 0->1
- o_fall  out  CHANNELS  one-cycle pulse when o_level goes 1->0
- o_any_change  out  1  OR of (o_rise | o_fall), registered together with them
- o_busy  out  CHANNELS  channel not in IDLE (locked out or qualifying)

Behaviour:

Reset:
- Reset is synchronous, active-low; sampled on posedge i_clk, overrides everything.
- While i_rst_n=0:
  - all sync flops and o_level = INIT_LEVEL;
  - o_rise, o_fall, o_any_change, o_busy = 0;
  - all channel FSMs = IDLE, counters = 0.
- Reset asserted mid-lockout or mid-qualification aborts the operation. No strobe is emitted.
- First cycle after reset release: no strobe unless the sampled input already differs (normal rules apply).

Synchroniser:
- i_raw[k] passes through SYNC_STAGES flops. s[k] is the last stage.
- s[k] reflects a raw change SYNC_STAGES edges later.

Per-channel counter:
- Width $clog2(CLK_WAIT+1).
- Never wraps; saturates by construction through FSM exit.

LOCKOUT mode (MODE=0), states IDLE, LOCK:
- IDLE, s!=o_level:
  - at that edge o_level<=s;
  - rise/fall strobe asserted for exactly the next cycle;
  - counter<=0; state<=LOCK.
- LOCK:
  - counter increments each cycle; s is ignored;
  - when counter==CLK_WAIT-1, state<=IDLE.
- Channel is locked for exactly CLK_WAIT cycles.
- Latency raw->o_level: SYNC_STAGES+1 edges.

STABLE mode (MODE=1), states IDLE, QUAL:
- IDLE, s!=o_level: counter<=0, state<=QUAL.
- QUAL, s==o_level: state<=IDLE, counter<=0, no strobe (glitch rejected).
- QUAL, s!=o_level, counter<CLK_WAIT-1: counter++.
- QUAL, s!=o_level, counter==CLK_WAIT-1:
  - o_level<=s; strobe next cycle; state<=IDLE.
- A change is accepted after CLK_WAIT+1 consecutive differing samples of s.
- Latency raw->o_level: SYNC_STAGES+1+CLK_WAIT edges.

Strobes and flags:
- o_rise/o_fall are registered and never both high on one channel.
- The strobe coincides with the first cycle the new o_level is visible.
- o_busy[k]=1 whenever channel k is in LOCK or QUAL.

Channel independence:
- Channels are fully independent.
- Simultaneous changes on several channels produce simultaneous strobes. o_any_change is a single pulse in that cycle.

Test Plan:
- CHANNELS=4, CLK_WAIT=4, SYNC_STAGES=2, MODE=0: hold reset, raw=4'b1111 -> o_level=0000, no strobes. Release reset -> all o_rise=1 on one cycle at edge 3 after release; o_busy=1111 for 4 cycles.
- MODE=0, ch0: raw 0->1, then 1-cycle bounces to 0 and back inside the lockout -> exactly one o_rise[0]; o_level[0]=1 throughout. Raw held 0 after lockout -> o_fall[0] at the first IDLE sample +1.
- MODE=1: ch1 raw pulse high for 3 cycles -> no strobe, o_level[1]=0, o_busy[1] returns 0. Raw high for 6 cycles -> o_rise[1] exactly 2+1+4=7 edges after raw rise.
- MODE=1: ch2 toggles every cycle for 50 cycles -> o_level[2] never changes, zero strobes.
- Either mode: ch0 and ch3 change on the same edge -> o_rise[0] and o_rise[3] in the same cycle, single-cycle o_any_change.
- Reset asserted during LOCK (MODE=0) and during QUAL (MODE=1) -> next cycle o_busy=0, o_level=INIT_LEVEL, no strobe.
